// File: rtl/ram_burst_control_unit.sv
// Multi-beat RAM burst sequencer: address load, per-beat issue/wait/beat
// handshake with programmable wait states, MemDone ready and wait timeout.
module ram_burst_control_unit #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned LEN_W  = 3,
    parameter int unsigned WAIT_W = 4,
    parameter int unsigned TMO_W  = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              RW,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [LEN_W-1:0]  Len,
    input  logic [WAIT_W-1:0] WaitCycles,
    input  logic              MemDone,
    output logic [2:0]        State,
    output logic              Busy,
    output logic [ADDR_W-1:0] Addr,
    output logic              MemEn,
    output logic              MemRW,
    output logic [1:0]        CM,
    output logic [1:0]        SM,
    output logic              Ld,
    output logic              First,
    output logic              Last,
    output logic              Strobe,
    output logic              DoneOut,
    output logic              Err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_LOAD   = 3'b001,
        S_ISSUE  = 3'b010,
        S_WAIT   = 3'b011,
        S_BEAT   = 3'b100,
        S_FINISH = 3'b101,
        S_ILL6   = 3'b110,
        S_ILL7   = 3'b111
    } state_e;

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [WAIT_W-1:0]   wcfg_q, wcfg_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                rw_q, rw_d;
    logic                err_q, err_d;

    // State and captured-burst registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            wcfg_q  <= '0;
            wait_q  <= '0;
            tmo_q   <= '0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            wcfg_q  <= wcfg_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
        end
    end

    // Next-state sequencing and Moore output decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        beat_d  = beat_q;
        len_d   = len_q;
        wcfg_d  = wcfg_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        rw_d    = rw_q;
        err_d   = err_q;

        Busy    = 1'b1;
        MemEn   = 1'b0;
        CM      = 2'b11;
        SM      = 2'b00;
        Ld      = 1'b0;
        First   = 1'b0;
        Last    = 1'b0;
        Strobe  = 1'b0;
        DoneOut = 1'b0;

        case (state_q)
            S_IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    rw_d    = RW;
                    base_d  = BaseAddr;
                    len_d   = Len;
                    wcfg_d  = WaitCycles;
                    err_d   = 1'b0;
                    beat_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                Ld      = 1'b1;
                CM      = 2'b00;
                SM      = 2'b10;
                addr_d  = base_q;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                MemEn   = 1'b1;
                CM      = rw_q ? 2'b01 : 2'b10;
                SM      = 2'b01;
                First   = (beat_q == '0);
                wait_d  = wcfg_q;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                MemEn  = 1'b1;
                CM     = rw_q ? 2'b01 : 2'b10;
                SM     = 2'b01;
                wait_d = (wait_q == '0) ? '0 : wait_q - WAIT_W'(1);
                tmo_d  = tmo_q + TMO_W'(1);
                // Ready with wait expired takes priority over a coincident timeout
                if ((wait_q == '0) && MemDone) begin
                    state_d = S_BEAT;
                end else if (tmo_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_BEAT: begin
                Strobe = 1'b1;
                CM     = rw_q ? 2'b01 : 2'b10;
                SM     = 2'b01;
                Last   = (beat_q == len_q);
                if (beat_q == len_q) begin
                    state_d = S_FINISH;
                end else begin
                    beat_d  = beat_q + LEN_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: begin
                DoneOut = 1'b1;
                CM      = 2'b01;
                SM      = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                Busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign State = state_q;
    assign Addr  = addr_q;
    assign MemRW = rw_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_ram_burst_control_unit.sv
// Directed bench for ram_burst_control_unit with a beat scoreboard.
module tb_ram_burst_control_unit;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       RW;
    logic [8:0] BaseAddr;
    logic [2:0] Len;
    logic [3:0] WaitCycles;
    logic       MemDone;
    logic [2:0] State;
    logic       Busy;
    logic [8:0] Addr;
    logic       MemEn;
    logic       MemRW;
    logic [1:0] CM;
    logic [1:0] SM;
    logic       Ld;
    logic       First;
    logic       Last;
    logic       Strobe;
    logic       DoneOut;
    logic       Err;

    ram_burst_control_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .RW(RW),
        .BaseAddr(BaseAddr), .Len(Len), .WaitCycles(WaitCycles),
        .MemDone(MemDone), .State(State), .Busy(Busy), .Addr(Addr),
        .MemEn(MemEn), .MemRW(MemRW), .CM(CM), .SM(SM), .Ld(Ld),
        .First(First), .Last(Last), .Strobe(Strobe), .DoneOut(DoneOut),
        .Err(Err)
    );

    typedef struct {
        logic [8:0] addr;
        logic       last;
        logic       rw;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_err    = 0;
    int    done_cnt = 0;
    int    exp_done = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every Strobe must match the next expected beat
    always @(negedge Clk) begin
        if (Reset === 1'b1 && Strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'(Addr), 32'h7FFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_addr", 32'(Addr), 32'(e.addr));
                chk("beat_last", 32'(Last), 32'(e.last));
                chk("beat_rw", 32'(MemRW), 32'(e.rw));
            end
        end
        if (Reset === 1'b1 && DoneOut === 1'b1) done_cnt++;
    end

    // Drive a Start at a negedge and queue the beats the burst should produce
    task automatic kick(input bit rw, input logic [8:0] base, input int len, input int w, input bit md);
        @(negedge Clk);
        Start      = 1'b1;
        RW         = rw;
        BaseAddr   = base;
        Len        = 3'(len);
        WaitCycles = 4'(w);
        MemDone    = md;
        if (md) begin
            for (int b = 0; b <= len; b++) begin
                beat_t e;
                e.addr = 9'(base + 9'(b));
                e.last = (b == len);
                e.rw   = rw;
                exp_q.push_back(e);
            end
        end
        exp_done++;
        @(negedge Clk);
        Start      = 1'b0;
        RW         = ~rw;
        BaseAddr   = ~base;
        Len        = ~3'(len);
        WaitCycles = ~4'(w);
    endtask

    // Full burst with MemDone high, checking the state walk cycle by cycle
    task automatic run_burst(input bit rw, input logic [8:0] base, input int len, input int w, input bit poke);
        kick(rw, base, len, w, 1'b1);
        chk("load_state", 32'(State), 32'd1);
        chk("load_ld", 32'(Ld), 32'd1);
        chk("load_err", 32'(Err), 32'd0);
        for (int b = 0; b <= len; b++) begin
            @(negedge Clk);
            Start = 1'b0;
            chk("issue_state", 32'(State), 32'd2);
            chk("issue_first", 32'(First), 32'(b == 0));
            chk("issue_addr", 32'(Addr), 32'(9'(base + 9'(b))));
            chk("issue_cm", 32'(CM), rw ? 32'd1 : 32'd2);
            for (int k = 0; k <= w; k++) begin
                @(negedge Clk);
                Start = 1'b0;
                chk("wait_state", 32'(State), 32'd3);
                chk("wait_memrw", 32'(MemRW), 32'(rw));
                if (poke && b == 1 && k == 0) begin
                    Start = 1'b1; RW = ~rw; BaseAddr = 9'h0; Len = 3'd0; WaitCycles = 4'd7;
                end
            end
            @(negedge Clk);
            Start = 1'b0;
            chk("beat_state", 32'(State), 32'd4);
        end
        @(negedge Clk);
        chk("finish_state", 32'(State), 32'd5);
        chk("finish_done", 32'(DoneOut), 32'd1);
        @(negedge Clk);
        chk("end_idle", 32'(State), 32'd0);
        chk("end_busy", 32'(Busy), 32'd0);
    endtask

    initial begin
        int waits;
        bit hit;
        Reset = 1'b1; Start = 1'b0; RW = 1'b0; BaseAddr = '0; Len = '0;
        WaitCycles = '0; MemDone = 1'b0;

        // Asynchronous reset
        #3 Reset = 1'b0;
        #1;
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_cm", 32'(CM), 32'd3);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_addr", 32'(Addr), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk("idle_hold", 32'(State), 32'd0);

        // Single-beat read
        run_burst(1'b1, 9'h010, 0, 0, 1'b0);
        // Four-beat write with address wrap
        run_burst(1'b0, 9'h1FE, 3, 2, 1'b0);

        // Timeout with MemDone held low
        kick(1'b1, 9'h020, 1, 0, 1'b0);
        waits = 0; hit = 0;
        for (int i = 0; i < 200; i++) begin
            if (State == 3'd3) waits++;
            if (State == 3'd5) begin hit = 1; break; end
            @(negedge Clk);
        end
        chk("tmo_reached", 32'(hit), 32'd1);
        chk("tmo_err", 32'(Err), 32'd1);
        chk("tmo_done", 32'(DoneOut), 32'd1);
        chk("tmo_waits", 32'(waits), 32'd64);
        repeat (3) @(negedge Clk);
        chk("tmo_idle", 32'(State), 32'd0);
        chk("tmo_err_sticky", 32'(Err), 32'd1);
        // Next Start clears Err (checked at LOAD inside run_burst)
        run_burst(1'b1, 9'h030, 0, 1, 1'b0);

        // Start pulsed mid-burst is ignored
        run_burst(1'b0, 9'h100, 2, 1, 1'b1);

        // Reset during the 2nd beat's WAIT
        kick(1'b0, 9'h0A0, 3, 2, 1'b1);
        repeat (7) @(negedge Clk);
        chk("pre_rst_wait", 32'(State), 32'd3);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_state", 32'(State), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_done", 32'(DoneOut), 32'd0);
        chk("mid_rst_pending", 32'(exp_q.size()), 32'd3);
        exp_q.delete();
        exp_done--;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        run_burst(1'b0, 9'h0A0, 3, 2, 1'b0);

        repeat (2) @(negedge Clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
